// File: rtl/out_port_rx_pkg.sv
// Shared types and widths for the output-port byte serializer.
package out_port_rx_pkg;

   localparam int unsigned WORD_W         = 32;
   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

   typedef enum logic {
      IDLE,
      SEND
   } ser_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/level and synchronous clear.
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 4
) (
   input  logic                     clk_i,
   input  logic                     clr_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [Width-1:0]         data_i,
   output logic [Width-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(Depth):0]   level_o
);

   localparam int unsigned AW = $clog2(Depth);
   localparam int unsigned LW = AW + 1;
   localparam logic [AW-1:0] PtrOne = 1;
   localparam logic [LW-1:0] LvlOne = 1;

   logic [Width-1:0] mem_q [Depth];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    level_q, level_d;
   logic             full_q, empty_q;
   logic             do_push, do_pop;

   assign do_pop  = pop_i && !empty_q;
   assign do_push = push_i && (!full_q || do_pop);

   always_comb begin
      level_d = level_q;
      if (do_push && !do_pop) begin
         level_d = level_q + LvlOne;
      end else if (do_pop && !do_push) begin
         level_d = level_q - LvlOne;
      end
   end

   // Pointers wrap naturally because Depth is a power of two.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + PtrOne;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PtrOne;
         end
         level_q <= level_d;
         full_q  <= (level_d == LW'(Depth));
         empty_q <= (level_d == '0);
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign level_o = level_q;

endmodule

// File: rtl/out_port_rx.sv
// Output-port receiver: buffers 32-bit CPU writes and streams them out LSB-first as bytes.
// Define OUT_PORT_RX_OVF_CNT_EN to build the saturating dropped-write counter.
module out_port_rx
   import out_port_rx_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     clear,
   input  logic                     OutPortin,
   input  logic [31:0]              BusMuxOut,
   output logic [7:0]               byte_data,
   output logic                     byte_valid,
   input  logic                     byte_ready,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [7:0]               ovf_count
);

   localparam logic [IDX_W-1:0] IdxOne  = 1;
   localparam logic [IDX_W-1:0] IdxLast = IDX_W'(BYTES_PER_WORD - 1);

   ser_state_e        state_q;
   logic [WORD_W-1:0] shreg_q;
   logic [IDX_W-1:0]  idx_q;
   logic              valid_q;
   logic              ovf_q;

   logic [WORD_W-1:0] fifo_dout;
   logic              fifo_full, fifo_empty, fifo_pop;
   logic              last_byte, drop;

   sync_fifo #(
      .Width (WORD_W),
      .Depth (DEPTH)
   ) u_fifo (
      .clk_i   (clock),
      .clr_i   (clear),
      .push_i  (OutPortin),
      .pop_i   (fifo_pop),
      .data_i  (BusMuxOut),
      .data_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level)
   );

   assign last_byte = (idx_q == IdxLast);

   // The next word is pulled on the same edge the last byte leaves, so words stream without gaps.
   always_comb begin
      fifo_pop = 1'b0;
      unique case (state_q)
         IDLE: fifo_pop = !fifo_empty;
         SEND: fifo_pop = byte_ready && last_byte && !fifo_empty;
      endcase
   end

   assign drop = OutPortin && fifo_full && !fifo_pop;

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= IDLE;
         shreg_q <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  shreg_q <= fifo_dout;
                  idx_q   <= '0;
                  valid_q <= 1'b1;
                  state_q <= SEND;
               end
            end
            SEND: begin
               if (byte_ready) begin
                  if (!last_byte) begin
                     shreg_q <= shreg_q >> BYTE_W;
                     idx_q   <= idx_q + IdxOne;
                  end else if (!fifo_empty) begin
                     shreg_q <= fifo_dout;
                     idx_q   <= '0;
                  end else begin
                     valid_q <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         ovf_q <= 1'b0;
      end else if (drop) begin
         ovf_q <= 1'b1;
      end
   end

`ifdef OUT_PORT_RX_OVF_CNT_EN
   logic [7:0] ovf_cnt_q;

   always_ff @(posedge clock) begin
      if (clear) begin
         ovf_cnt_q <= '0;
      end else if (drop && (ovf_cnt_q != 8'hFF)) begin
         ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
   end

   assign ovf_count = ovf_cnt_q;
`else
   assign ovf_count = '0;
`endif

   assign byte_data  = shreg_q[BYTE_W-1:0];
   assign byte_valid = valid_q;
   assign full       = fifo_full;
   assign empty      = fifo_empty;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_out_port_rx.sv
// Self-checking bench for out_port_rx: directed scenarios plus a randomized stream against a
// byte-queue reference model.
module tb_out_port_rx;

   localparam int unsigned DEPTH = 4;
`ifdef OUT_PORT_RX_OVF_CNT_EN
   localparam logic [7:0] OvfOne = 8'd1;
`else
   localparam logic [7:0] OvfOne = 8'd0;
`endif

   logic        clock = 1'b0;
   logic        clear;
   logic        OutPortin;
   logic [31:0] BusMuxOut;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_ready;
   logic        full;
   logic        empty;
   logic [2:0]  level;
   logic        overflow;
   logic [7:0]  ovf_count;

   int errors = 0;
   int checks = 0;

   out_port_rx #(
      .DEPTH (DEPTH)
   ) dut (
      .clock      (clock),
      .clear      (clear),
      .OutPortin  (OutPortin),
      .BusMuxOut  (BusMuxOut),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .full       (full),
      .empty      (empty),
      .level      (level),
      .overflow   (overflow),
      .ovf_count  (ovf_count)
   );

   always #5 clock = ~clock;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
      return 8'((w >> (8 * k)) & 32'hFF);
   endfunction

   task automatic do_clear();
      clear = 1'b1;
      OutPortin = 1'b0;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      clear = 1'b1; OutPortin = 1'b0; BusMuxOut = '0; byte_ready = 1'b0;
      tick(); tick();
      clear = 1'b0;
      checks++; if (level !== 3'd0) begin errors++;
         $display("FAIL reset_level got=%0d exp=0", level); end
      checks++; if (empty !== 1'b1) begin errors++;
         $display("FAIL reset_empty got=%b exp=1", empty); end
      checks++; if (full !== 1'b0) begin errors++;
         $display("FAIL reset_full got=%b exp=0", full); end
      checks++; if (byte_valid !== 1'b0) begin errors++;
         $display("FAIL reset_valid got=%b exp=0", byte_valid); end
      checks++; if (byte_data !== 8'h00) begin errors++;
         $display("FAIL reset_data got=%h exp=00", byte_data); end
      checks++; if (overflow !== 1'b0) begin errors++;
         $display("FAIL reset_overflow got=%b exp=0", overflow); end
      checks++; if (ovf_count !== 8'd0) begin errors++;
         $display("FAIL reset_ovf_count got=%0d exp=0", ovf_count); end
   endtask

   task automatic test_single_word();
      logic [31:0] w = 32'h44332211;
      byte_ready = 1'b1;
      OutPortin = 1'b1; BusMuxOut = w;
      tick();
      OutPortin = 1'b0;
      checks++; if (byte_valid !== 1'b0 || level !== 3'd1) begin errors++;
         $display("FAIL single_after_write valid=%b level=%0d exp valid=0 level=1",
                  byte_valid, level); end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (byte_valid !== 1'b1 || byte_data !== byte_of(w, k)) begin errors++;
            $display("FAIL single_byte%0d valid=%b data=%h exp valid=1 data=%h",
                     k, byte_valid, byte_data, byte_of(w, k)); end
      end
      tick();
      checks++; if (byte_valid !== 1'b0 || empty !== 1'b1) begin errors++;
         $display("FAIL single_end valid=%b empty=%b exp valid=0 empty=1", byte_valid, empty); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] words [2];
      words[0] = 32'hA0A1A2A3;
      words[1] = 32'hB0B1B2B3;
      byte_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         OutPortin = 1'b1; BusMuxOut = words[i];
         tick();
      end
      OutPortin = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (byte_valid !== 1'b1 || byte_data !== byte_of(words[i/4], i % 4)) begin errors++;
            $display("FAIL b2b_byte%0d valid=%b data=%h exp valid=1 data=%h",
                     i, byte_valid, byte_data, byte_of(words[i/4], i % 4)); end
         tick();
      end
      checks++; if (byte_valid !== 1'b0) begin errors++;
         $display("FAIL b2b_end valid=%b exp=0", byte_valid); end
   endtask

   // Leaves the DUT full with words[0] parked in the serializer for test_full_pop.
   logic [31:0] ovf_words [7];

   task automatic test_overflow();
      do_clear();
      byte_ready = 1'b0;
      for (int i = 0; i < 7; i++) ovf_words[i] = $urandom;
      for (int i = 0; i < 6; i++) begin
         OutPortin = 1'b1; BusMuxOut = ovf_words[i];
         if (i == 5) begin
            checks++; if (full !== 1'b1 || level !== 3'd4 || overflow !== 1'b0) begin errors++;
               $display("FAIL ovf_prefull full=%b level=%0d overflow=%b exp 1 4 0",
                        full, level, overflow); end
         end
         tick();
      end
      OutPortin = 1'b0;
      checks++; if (level !== 3'd4 || full !== 1'b1) begin errors++;
         $display("FAIL ovf_level level=%0d full=%b exp 4 1", level, full); end
      checks++; if (overflow !== 1'b1) begin errors++;
         $display("FAIL ovf_flag got=%b exp=1", overflow); end
      checks++; if (ovf_count !== OvfOne) begin errors++;
         $display("FAIL ovf_count got=%0d exp=%0d", ovf_count, OvfOne); end
      checks++; if (byte_valid !== 1'b1 || byte_data !== byte_of(ovf_words[0], 0)) begin errors++;
         $display("FAIL ovf_head valid=%b data=%h exp 1 %h",
                  byte_valid, byte_data, byte_of(ovf_words[0], 0)); end
   endtask

   task automatic test_full_pop();
      byte_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         checks++; if (byte_data !== byte_of(ovf_words[0], k)) begin errors++;
            $display("FAIL fullpop_byte%0d got=%h exp=%h", k, byte_data, byte_of(ovf_words[0], k));
         end
         tick();
      end
      OutPortin = 1'b1; BusMuxOut = ovf_words[6];
      checks++; if (byte_data !== byte_of(ovf_words[0], 3) || full !== 1'b1) begin errors++;
         $display("FAIL fullpop_last data=%h full=%b exp %h 1",
                  byte_data, full, byte_of(ovf_words[0], 3)); end
      tick();
      OutPortin = 1'b0; byte_ready = 1'b0;
      checks++; if (level !== 3'd4 || full !== 1'b1) begin errors++;
         $display("FAIL fullpop_level level=%0d full=%b exp 4 1", level, full); end
      checks++; if (overflow !== 1'b1 || ovf_count !== OvfOne) begin errors++;
         $display("FAIL fullpop_ovf overflow=%b count=%0d exp 1 %0d", overflow, ovf_count, OvfOne);
      end
      checks++; if (byte_valid !== 1'b1 || byte_data !== byte_of(ovf_words[1], 0)) begin errors++;
         $display("FAIL fullpop_next valid=%b data=%h exp 1 %h",
                  byte_valid, byte_data, byte_of(ovf_words[1], 0)); end
   endtask

   task automatic test_clear_mid();
      do_clear();
      byte_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         OutPortin = 1'b1; BusMuxOut = $urandom;
         tick();
      end
      OutPortin = 1'b0;
      checks++; if (level !== 3'd2) begin errors++;
         $display("FAIL clr_queued level=%0d exp=2", level); end
      byte_ready = 1'b1;
      tick(); tick();
      byte_ready = 1'b0;
      clear = 1'b1; OutPortin = 1'b1; BusMuxOut = 32'h12345678;
      tick();
      clear = 1'b0; OutPortin = 1'b0;
      checks++; if (byte_valid !== 1'b0 || byte_data !== 8'h00) begin errors++;
         $display("FAIL clr_out valid=%b data=%h exp 0 00", byte_valid, byte_data); end
      checks++; if (level !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++;
         $display("FAIL clr_fifo level=%0d empty=%b full=%b exp 0 1 0", level, empty, full); end
      checks++; if (overflow !== 1'b0) begin errors++;
         $display("FAIL clr_overflow got=%b exp=0", overflow); end
      byte_ready = 1'b1; OutPortin = 1'b1; BusMuxOut = 32'h000000FF;
      tick();
      OutPortin = 1'b0;
      tick();
      checks++; if (byte_valid !== 1'b1 || byte_data !== 8'hFF) begin errors++;
         $display("FAIL clr_fresh valid=%b data=%h exp 1 ff", byte_valid, byte_data); end
      for (int k = 0; k < 4; k++) tick();
      checks++; if (byte_valid !== 1'b0 || level !== 3'd0) begin errors++;
         $display("FAIL clr_drained valid=%b level=%0d exp 0 0", byte_valid, level); end
   endtask

   task automatic test_random_stream();
      logic [7:0] exp_q [$];
      logic [7:0] held;
      logic [31:0] w;
      logic       hold = 1'b0;
      int         written = 0;
      int         cycles = 0;
      do_clear();
      while ((written < 100 || exp_q.size() != 0) && cycles < 5000) begin
         if (hold) begin
            checks++; if (byte_valid !== 1'b1 || byte_data !== held) begin errors++;
               $display("FAIL rnd_stable cyc=%0d valid=%b data=%h exp 1 %h",
                        cycles, byte_valid, byte_data, held); end
         end
         byte_ready = 1'($urandom_range(0, 1));
         OutPortin = 1'b0;
         if (written < 100 && !full && ($urandom_range(0, 2) != 0)) begin
            w = $urandom;
            OutPortin = 1'b1; BusMuxOut = w;
            for (int k = 0; k < 4; k++) exp_q.push_back(byte_of(w, k));
            written++;
         end
         if (byte_valid && byte_ready) begin
            checks++;
            if (exp_q.size() == 0) begin errors++;
               $display("FAIL rnd_extra cyc=%0d data=%h exp no byte", cycles, byte_data);
            end else if (byte_data !== exp_q[0]) begin errors++;
               $display("FAIL rnd_byte cyc=%0d got=%h exp=%h", cycles, byte_data, exp_q[0]);
               void'(exp_q.pop_front());
            end else begin
               void'(exp_q.pop_front());
            end
         end
         hold = byte_valid && !byte_ready;
         held = byte_data;
         tick();
         cycles++;
      end
      OutPortin = 1'b0;
      checks++; if (written != 100 || exp_q.size() != 0) begin errors++;
         $display("FAIL rnd_timeout written=%0d pending=%0d exp 100 0", written, exp_q.size()); end
      checks++; if (overflow !== 1'b0) begin errors++;
         $display("FAIL rnd_overflow got=%b exp=0", overflow); end
   endtask

   initial begin
      @(negedge clock);
      test_reset();
      test_single_word();
      test_back_to_back();
      test_overflow();
      test_full_pop();
      test_clear_mid();
      test_random_stream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
